// File: rtl/msfsm_toggle_out_monitor_if.sv
// Event and level bundle between the MSFSM toggle composition and its output monitor.
// The master drives Ri and the event pulses; the slave (monitor) drives the rebuilt levels.
interface msfsm_toggle_out_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             Ri;
    logic             Ro1_PLUS;
    logic             Ro1_MINUS;
    logic             Ro2_PLUS;
    logic             Ro2_MINUS;
    logic             Ro1;
    logic             Ro2;
    logic             evt_accept;
    logic [1:0]       seq_state;
    logic [CNT_W-1:0] cycle_count;
    logic             err;
    logic [2:0]       err_code;

    modport master (
        output Ri, Ro1_PLUS, Ro1_MINUS, Ro2_PLUS, Ro2_MINUS,
        input  Ro1, Ro2, evt_accept, seq_state, cycle_count, err, err_code
    );

    modport slave (
        input  Ri, Ro1_PLUS, Ro1_MINUS, Ro2_PLUS, Ro2_MINUS,
        output Ro1, Ro2, evt_accept, seq_state, cycle_count, err, err_code
    );
endinterface

// File: rtl/msfsm_toggle_out_monitor.sv
// Rebuilds Ro1/Ro2 levels from event pulses, checks toggle order and Ri agreement,
// and counts completed Ro1+/Ro1-/Ro2+/Ro2- cycles.
module msfsm_toggle_out_monitor #(
    parameter int unsigned CNT_W  = 8,
    parameter bit          STICKY = 1'b1
) (
    input logic                        clk,
    input logic                        reset,
    msfsm_toggle_out_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        ExpR1p = 2'd0,
        ExpR1m = 2'd1,
        ExpR2p = 2'd2,
        ExpR2m = 2'd3
    } seq_e;

    localparam logic [2:0] ErrNone  = 3'd0;
    localparam logic [2:0] ErrMulti = 3'd1;
    localparam logic [2:0] ErrOrder = 3'd2;
    localparam logic [2:0] ErrRi    = 3'd3;

    seq_e             state_q;
    logic             ro1_q;
    logic             ro2_q;
    logic             evt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic [2:0]       code_q;

    logic [3:0] ev;
    logic [3:0] expected;
    logic       multi;
    logic       accept;
    logic       plus_evt;
    logic [2:0] cause;

    // ev bit order matches seq_e: bit k is the event expected in state k.
    always_comb begin
        ev       = {bus.Ro2_MINUS, bus.Ro2_PLUS, bus.Ro1_MINUS, bus.Ro1_PLUS};
        expected = 4'b0001 << state_q;
        multi    = (ev & (ev - 4'd1)) != 4'd0;
        accept   = (ev == expected);
        plus_evt = |(ev & 4'b0101);
        cause    = ErrNone;
        if (multi) begin
            cause = ErrMulti;
        end else if (ev != 4'd0 && !accept) begin
            cause = ErrOrder;
        end else if (accept && (bus.Ri != plus_evt)) begin
            cause = ErrRi;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ExpR1p;
            ro1_q   <= 1'b0;
            ro2_q   <= 1'b0;
            evt_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= ErrNone;
        end else begin
            evt_q <= accept;
            if (accept) begin
                unique case (state_q)
                    ExpR1p: begin
                        ro1_q   <= 1'b1;
                        state_q <= ExpR1m;
                    end
                    ExpR1m: begin
                        ro1_q   <= 1'b0;
                        state_q <= ExpR2p;
                    end
                    ExpR2p: begin
                        ro2_q   <= 1'b1;
                        state_q <= ExpR2m;
                    end
                    ExpR2m: begin
                        ro2_q   <= 1'b0;
                        state_q <= ExpR1p;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                    default: state_q <= ExpR1p;
                endcase
            end
            if (STICKY) begin
                if (!err_q && cause != ErrNone) begin
                    err_q  <= 1'b1;
                    code_q <= cause;
                end
            end else begin
                err_q  <= (cause != ErrNone);
                code_q <= cause;
            end
        end
    end

    assign bus.Ro1         = ro1_q;
    assign bus.Ro2         = ro2_q;
    assign bus.evt_accept  = evt_q;
    assign bus.seq_state   = state_q;
    assign bus.cycle_count = cnt_q;
    assign bus.err         = err_q;
    assign bus.err_code    = code_q;
endmodule

// File: doc/msfsm_toggle_out_monitor.md
Name: msfsm_toggle_out_monitor

Overview:
- Downstream stage of the synchronous Mealy MSFSM toggle composition.
- Consumes the one-cycle output event pulses Ro1_PLUS/Ro1_MINUS/Ro2_PLUS/Ro2_MINUS and rebuilds the level-encoded environment outputs Ro1 and Ro2.
- Checks the event stream against toggle protocol order and against the input level Ri, and counts completed toggle cycles.
- Sits between the MSFSM composition and the testbench/environment; used in simulation and on-chip.

Parameters:
- CNT_W, 8, width of completed-toggle-cycle counter.
- STICKY, 1, 1 = err/err_code hold the first error until reset; 0 = err is a one-cycle pulse per error.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- Ri  input  1  environment input level (the level whose edges produced Ri_PLUS/Ri_MINUS)
- Ro1_PLUS  input  1  event pulse, Ro1 rises
- Ro1_MINUS  input  1  event pulse, Ro1 falls
- Ro2_PLUS  input  1  event pulse, Ro2 rises
- Ro2_MINUS  input  1  event pulse, Ro2 falls
- Ro1  output  1  rebuilt level of output 1
- Ro2  output  1  rebuilt level of output 2
- evt_accept  output  1  one-cycle pulse, an event was accepted in the previous cycle
- seq_state  output  2  expected-next-event state
- cycle_count  output  CNT_W  number of completed toggle cycles
- err  output  1  protocol error flag
- err_code  output  3  error cause: 0 none, 1 MULTI, 2 ORDER, 3 RI_MISMATCH

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high.
  - Reset has priority over any events sampled in the same cycle.
- Reset values: Ro1=0, Ro2=0, evt_accept=0, seq_state=EXP_R1P, cycle_count=0, err=0, err_code=0.
- Output timing: all outputs are registered. An event sampled at edge N is reflected in the outputs after edge N.
- seq_state encoding and transitions:
  - 0 EXP_R1P -> 1 on accepted Ro1_PLUS.
  - 1 EXP_R1M -> 2 on accepted Ro1_MINUS.
  - 2 EXP_R2P -> 3 on accepted Ro2_PLUS.
  - 3 EXP_R2M -> 0 on accepted Ro2_MINUS; cycle_count increments at this transition.
- Per-cycle evaluation, with n = number of asserted event inputs:
  - n=0: no change. evt_accept=0. In pulse mode, err=0.
  - n>=2: error MULTI. No level or state change.
  - n=1, event is not the one expected by seq_state: error ORDER. No level or state change.
  - n=1, event matches seq_state: accepted.
    - Ro1 or Ro2 is set (PLUS) or cleared (MINUS).
    - seq_state advances.
    - evt_accept=1 for one cycle.
- RI_MISMATCH check on an accepted event:
  - A PLUS event requires Ri=1; a MINUS event requires Ri=0.
  - On mismatch the event is still applied (levels and state advance) and error RI_MISMATCH is raised in the same cycle.
- Error priority within a cycle: MULTI > ORDER > RI_MISMATCH. Only one code is recorded.
- STICKY=1:
  - The first error sets err=1 and captures its err_code.
  - Later errors do not overwrite err_code.
  - Only reset clears err and err_code.
- STICKY=0:
  - err=1 and err_code=cause for exactly one cycle per erroneous sample.
  - Otherwise err=0 and err_code=0.
- cycle_count wraps modulo 2^CNT_W (2^CNT_W-1 -> 0). The wrap is not an error.
- Errors never block later checking: accepting continues from the unchanged seq_state.
- Back-to-back events in consecutive cycles are legal; each cycle is evaluated independently.
- Reset asserted mid-sequence (e.g. seq_state=2, Ro1=0) returns all state to reset values on the next edge. Events present in that cycle are ignored.

Test Plan:
- Reset then Ri=1 with Ro1_PLUS; Ri=0 with Ro1_MINUS; Ri=1 with Ro2_PLUS; Ri=0 with Ro2_MINUS, one pulse per cycle, each with the correct Ri level -> Ro1 goes 1 then 0, Ro2 goes 1 then 0; evt_accept pulses 4 times; seq_state 0,1,2,3,0; cycle_count=1; err=0.
- From reset, pulse Ro2_PLUS -> err=1, err_code=2; Ro2 stays 0; seq_state stays 0. A following legal Ro1_PLUS with Ri=1 is accepted and err_code stays 2 (STICKY=1).
- Ro1_PLUS and Ro2_PLUS asserted in the same cycle -> err_code=1; Ro1=Ro2=0; seq_state=0.
- Ro1_PLUS with Ri=0 -> Ro1=1, seq_state=1, err_code=3.
- CNT_W=2: run 4 full legal cycles -> cycle_count sequence 1,2,3,0 with no error.
- STICKY=0: an ORDER error followed by an idle cycle -> err high for exactly one cycle, then 0. Separately, assert reset together with Ro1_PLUS at seq_state=2 -> all outputs at reset values after the edge.
